// File: rtl/loss_epoch_ctrl.sv
// rtl/loss_epoch_ctrl.sv - batch sequencer for the squared-error loss unit with saturating sum
module loss_epoch_ctrl #(
  parameter int CNT_W  = 8,
  parameter int PRED_W = 21,
  parameter int TGT_W  = 4,
  parameter int LOSS_W = 42,
  parameter int SUM_W  = 50
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_samples_i,
  input  logic              pred_valid_i,
  output logic              pred_ready_o,
  input  logic [PRED_W-1:0] pred_i,
  input  logic [TGT_W-1:0]  target_i,
  output logic              calc_en_o,
  output logic [PRED_W-1:0] calc_pred_o,
  output logic [TGT_W-1:0]  calc_tgt_o,
  input  logic [LOSS_W-1:0] loss_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic              sat_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CALC,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  remain;
  logic [SUM_W:0]    sum_ext;

  // One extra bit catches the carry out of the batch sum for saturation.
  assign sum_ext = {1'b0, sum_o} + {{(SUM_W + 1 - LOSS_W){1'b0}}, loss_i};

  // State register; asynchronous reset drops any in-flight sample.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt    = state;
    pred_ready_o = 1'b0;
    calc_en_o    = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = (num_samples_i != '0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        pred_ready_o = 1'b1;
        if (pred_valid_i) begin
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        calc_en_o = 1'b1;
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        state_nxt = (remain == CNT_W'(1)) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: batch count, operand capture and saturating accumulation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      remain      <= '0;
      calc_pred_o <= '0;
      calc_tgt_o  <= '0;
      sum_o       <= '0;
      sat_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            remain <= num_samples_i;
            sum_o  <= '0;
            sat_o  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pred_valid_i) begin
            calc_pred_o <= pred_i;
            calc_tgt_o  <= target_i;
          end
        end
        S_ACCUM: begin
          if (sum_ext[SUM_W]) begin
            sum_o <= '1;
            sat_o <= 1'b1;
          end else begin
            sum_o <= sum_ext[SUM_W-1:0];
          end
          remain <= remain - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loss_epoch_ctrl.sv
// tb/tb_loss_epoch_ctrl.sv - directed vector bench for loss_epoch_ctrl
module tb_loss_epoch_ctrl;

  localparam int CNT_W  = 8;
  localparam int PRED_W = 21;
  localparam int TGT_W  = 4;
  localparam int LOSS_W = 42;
  localparam int SUM_W  = 43;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [CNT_W-1:0]  num_samples_i;
  logic              pred_valid_i;
  logic              pred_ready_o;
  logic [PRED_W-1:0] pred_i;
  logic [TGT_W-1:0]  target_i;
  logic              calc_en_o;
  logic [PRED_W-1:0] calc_pred_o;
  logic [TGT_W-1:0]  calc_tgt_o;
  logic [LOSS_W-1:0] loss_i;
  logic [SUM_W-1:0]  sum_o;
  logic              sat_o;
  logic              busy_o;
  logic              done_o;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int acc_cnt = 0;

  logic              force_loss = 1'b0;
  logic [LOSS_W-1:0] force_val = '0;

  typedef struct {
    logic [PRED_W-1:0] pred;
    logic [TGT_W-1:0]  tgt;
    logic [63:0]       exp_sum;
  } vec_t;

  vec_t vecs[5];

  loss_epoch_ctrl #(
    .CNT_W(CNT_W), .PRED_W(PRED_W), .TGT_W(TGT_W), .LOSS_W(LOSS_W), .SUM_W(SUM_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_samples_i(num_samples_i),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o), .pred_i(pred_i),
    .target_i(target_i), .calc_en_o(calc_en_o), .calc_pred_o(calc_pred_o),
    .calc_tgt_o(calc_tgt_o), .loss_i(loss_i), .sum_o(sum_o), .sat_o(sat_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [LOSS_W-1:0] sq(input logic [PRED_W-1:0] p, input logic [TGT_W-1:0] t);
    logic [63:0] d;
    d = (p >= PRED_W'(t)) ? 64'(p) - 64'(t) : 64'(t) - 64'(p);
    return LOSS_W'(d * d);
  endfunction

  // Loss unit model: captures operands while enabled, result visible next cycle.
  always @(posedge clk_i) begin
    if (calc_en_o) loss_i <= force_loss ? force_val : sq(calc_pred_o, calc_tgt_o);
  end

  // Event counters for enable pulses and accepted samples.
  always @(posedge clk_i) begin
    if (calc_en_o) en_cnt++;
    if (pred_valid_i && pred_ready_o) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_start(input int n);
    start_i = 1'b1;
    num_samples_i = CNT_W'(n);
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [PRED_W-1:0] p, input logic [TGT_W-1:0] t, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) tick();
    pred_i = p;
    target_i = t;
    pred_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (pred_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    pred_valid_i = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int e0;
    int a0;
    bit seen;
    logic [63:0] ones;
    ones = (64'd1 << SUM_W) - 64'd1;

    vecs[0] = '{pred: 21'd7,        tgt: 4'd3,  exp_sum: 64'd16};
    vecs[1] = '{pred: 21'd0,        tgt: 4'd0,  exp_sum: 64'd0};
    vecs[2] = '{pred: 21'd3,        tgt: 4'd7,  exp_sum: 64'd16};
    vecs[3] = '{pred: 21'd100,      tgt: 4'd5,  exp_sum: 64'd9025};
    vecs[4] = '{pred: 21'h1FFFFF,   tgt: 4'd15, exp_sum: 64'd2097136 * 64'd2097136};

    rst_i = 1'b0;
    start_i = 1'b0;
    num_samples_i = '0;
    pred_valid_i = 1'b0;
    pred_i = '0;
    target_i = '0;
    repeat (3) tick();

    check("rst_sum", 64'(sum_o), 64'd0);
    check("rst_sat", 64'(sat_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ready", 64'(pred_ready_o), 64'd0);
    check("rst_en", 64'(calc_en_o), 64'd0);
    check("rst_pred", 64'(calc_pred_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // Single-sample latency walk-through
    do_start(1);
    check("wait_ready", 64'(pred_ready_o), 64'd1);
    send(21'd7, 4'd3, 0);
    check("lat_en", 64'(calc_en_o), 64'd1);
    check("lat_ready_low", 64'(pred_ready_o), 64'd0);
    tick();
    check("lat_accum_en", 64'(calc_en_o), 64'd0);
    check("lat_accum_busy", 64'(busy_o), 64'd1);
    tick();
    check("lat_done", 64'(done_o), 64'd1);
    check("lat_sum", 64'(sum_o), 64'd16);
    tick();
    check("lat_done_pulse", 64'(done_o), 64'd0);
    check("lat_idle", 64'(busy_o), 64'd0);

    // Table of single-sample batches
    for (int i = 0; i < 5; i++) begin
      e0 = en_cnt;
      do_start(1);
      send(vecs[i].pred, vecs[i].tgt, i % 3);
      wait_done();
      check($sformatf("vec%0d_sum", i), 64'(sum_o), vecs[i].exp_sum);
      check($sformatf("vec%0d_sat", i), 64'(sat_o), 64'd0);
      check($sformatf("vec%0d_en", i), 64'(en_cnt - e0), 64'd1);
      check($sformatf("vec%0d_hold", i), 64'(calc_pred_o), 64'(vecs[i].pred));
      tick();
    end

    // Three samples with valid gaps
    e0 = en_cnt;
    do_start(3);
    send(21'd5, 4'd1, 2);
    send(21'd0, 4'd1, 3);
    send(21'd2, 4'd2, 1);
    wait_done();
    check("n3_sum", 64'(sum_o), 64'd17);
    check("n3_en", 64'(en_cnt - e0), 64'd3);
    tick();
    check("n3_done_low", 64'(done_o), 64'd0);

    // Zero-length batch
    e0 = en_cnt;
    do_start(0);
    check("n0_done", 64'(done_o), 64'd1);
    check("n0_sum", 64'(sum_o), 64'd0);
    check("n0_sat", 64'(sat_o), 64'd0);
    tick();
    check("n0_done_low", 64'(done_o), 64'd0);
    check("n0_idle", 64'(busy_o), 64'd0);
    check("n0_no_en", 64'(en_cnt - e0), 64'd0);

    // Saturation with three maximal losses
    force_loss = 1'b1;
    force_val = '1;
    do_start(3);
    send(21'd1, 4'd0, 0);
    send(21'd1, 4'd0, 1);
    send(21'd1, 4'd0, 0);
    wait_done();
    check("sat_sum", 64'(sum_o), ones);
    check("sat_flag", 64'(sat_o), 64'd1);
    force_loss = 1'b0;
    tick();

    // Start re-pulsed while busy and valid held through CALC/ACCUM
    e0 = en_cnt;
    a0 = acc_cnt;
    start_i = 1'b1;
    num_samples_i = 8'd2;
    tick();
    num_samples_i = 8'd5;
    pred_i = 21'd9;
    target_i = 4'd1;
    pred_valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    start_i = 1'b0;
    pred_valid_i = 1'b0;
    if (!seen) check("busy_timeout", 64'd0, 64'd1);
    check("busy_accepts", 64'(acc_cnt - a0), 64'd2);
    check("busy_en", 64'(en_cnt - e0), 64'd2);
    check("busy_sum", 64'(sum_o), 64'd128);
    check("busy_sat_clr", 64'(sat_o), 64'd0);
    tick();
    check("busy_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset during ACCUM of sample 2 of 4
    do_start(4);
    send(21'd7, 4'd3, 0);
    send(21'd6, 4'd2, 0);
    tick();
    check("mid_busy", 64'(sum_o), 64'd16);
    rst_i = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_sum", 64'(sum_o), 64'd0);
    check("mid_rst_pred", 64'(calc_pred_o), 64'd0);
    check("mid_rst_tgt", 64'(calc_tgt_o), 64'd0);
    #1;
    rst_i = 1'b1;
    tick();
    check("post_rst_idle", 64'(busy_o), 64'd0);
    e0 = en_cnt;
    do_start(1);
    send(21'd5, 4'd1, 0);
    wait_done();
    check("restart_sum", 64'(sum_o), 64'd16);
    check("restart_sat", 64'(sat_o), 64'd0);
    check("restart_en", 64'(en_cnt - e0), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
